// File: rtl/instr_mem_fetch.sv
// Pipelined fetch-stage instruction memory with program-load port and flush.
// Define INSTR_MEM_BOUNDS_EN to flag misaligned/out-of-range fetches; otherwise addresses wrap.
module instr_mem_fetch #(
  parameter int                DATA_W    = 16,
  parameter int                DEPTH     = 64,
  parameter int                ADDR_W    = 16,
  parameter int                LAT       = 1,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(16'hEFFF)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     ready,
  input  logic                     flush,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ADDR_W-1:0]        rsp_addr,
  output logic                     rsp_err,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [DATA_W-1:0]        ld_data
);

  localparam int BW    = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);

  logic              accept;
  logic [IDX_W-1:0]  fetch_idx;
  logic              fetch_err;
  logic [DATA_W-1:0] fetch_data;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [LAT-1:0]    vld_q;
  logic [LAT-1:0]    vld_d;
  logic [LAT-1:0]    err_q;
  logic [LAT-1:0]    err_d;
  logic [DATA_W-1:0] data_q [LAT];
  logic [DATA_W-1:0] data_d [LAT];
  logic [ADDR_W-1:0] addr_q [LAT];
  logic [ADDR_W-1:0] addr_d [LAT];

  // A load write steals the cycle from fetch, so the two never collide on the array.
  assign ready  = !rst && !ld_we;
  assign accept = req && ready;

  always_comb begin
    fetch_idx = addr[BW +: IDX_W];
    fetch_err = 1'b0;
`ifdef INSTR_MEM_BOUNDS_EN
    if ((addr[BW-1:0] != '0) || ((addr >> (BW + IDX_W)) != '0)) begin
      fetch_err = 1'b1;
    end
`endif
    fetch_data = fetch_err ? HALT_WORD : mem_q[fetch_idx];
  end

`ifndef INSTR_MEM_BOUNDS_EN
  // Byte-offset and high address bits are ignored when addresses wrap.
  logic unused_addr;
  assign unused_addr = ^addr;
`endif

  always_comb begin
    mem_d = mem_q;
    if (ld_we) begin
      mem_d[ld_idx] = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= HALT_WORD;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Stage 0 captures the read at the accept edge; later stages only shift.
  // Payload moves only with a live valid so the output holds its last response.
  always_comb begin
    vld_d  = vld_q;
    err_d  = err_q;
    data_d = data_q;
    addr_d = addr_q;

    vld_d[0] = accept;
    if (accept) begin
      data_d[0] = fetch_data;
      addr_d[0] = addr;
      err_d[0]  = fetch_err;
    end

    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1] && !flush;
      if (vld_d[i]) begin
        data_d[i] = data_q[i-1];
        addr_d[i] = addr_q[i-1];
        err_d[i]  = err_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      err_q  <= err_d;
      data_q <= data_d;
      addr_q <= addr_d;
    end
  end

  assign rsp_valid = vld_q[LAT-1];
  assign rsp_data  = data_q[LAT-1];
  assign rsp_addr  = addr_q[LAT-1];
  assign rsp_err   = err_q[LAT-1];

endmodule
